alu_regfile_pipe: RTL and testbench

ALU_REGFILE_PIPE -- requirements
Module: alu_regfile_pipe

---
 rtl/alu_regfile_pkg.sv | 22 ++
 rtl/alu_regfile_pipe_alu.sv | 54 +++++
 rtl/alu_regfile_pipe.sv | 134 +++++++++++++
 tb/tb_alu_regfile_pipe.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_regfile_pkg.sv
// Shared definitions for the ALU/register-file pipeline.
//   alu_op_e   : 3-bit ALU operation encodings
//   FLAG_ZERO  : bit position of the zero flag in the ALU flag vector
//   FLAG_CARRY : bit position of the carry / no-borrow flag
package alu_regfile_pkg;

  typedef enum logic [2:0] {
    OP_AND    = 3'b000,
    OP_OR     = 3'b001,
    OP_NAND   = 3'b010,
    OP_NOR    = 3'b011,
    OP_ADD    = 3'b100,
    OP_SUB    = 3'b101,
    OP_XOR    = 3'b110,
    OP_PASS_B = 3'b111
  } alu_op_e;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int NFLAGS     = 2;

endpackage

// File: rtl/alu_regfile_pipe_alu.sv
// alu_core: purely combinational ALU.
//   i_a, i_b  : operands (WIDTH bits)
//   i_op      : operation (alu_op_e encoding)
//   o_result  : result, modulo 2^WIDTH
//   o_flags   : [FLAG_ZERO] result==0, [FLAG_CARRY] ADD carry-out / SUB no-borrow
module alu_core
  import alu_regfile_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]  i_a,
  input  logic [WIDTH-1:0]  i_b,
  input  logic [2:0]        i_op,
  output logic [WIDTH-1:0]  o_result,
  output logic [NFLAGS-1:0] o_flags
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;

  always_comb begin
    w_sum   = '0;
    w_res   = '0;
    w_carry = 1'b0;
    case (i_op)
      OP_AND:    w_res = i_a & i_b;
      OP_OR:     w_res = i_a | i_b;
      OP_NAND:   w_res = ~(i_a & i_b);
      OP_NOR:    w_res = ~(i_a | i_b);
      OP_ADD: begin
        w_sum   = {1'b0, i_a} + {1'b0, i_b};
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
      end
      // Two's-complement subtract; the carry-out is the no-borrow indication.
      OP_SUB: begin
        w_sum   = {1'b0, i_a} + {1'b0, ~i_b} + {{WIDTH{1'b0}}, 1'b1};
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
      end
      OP_XOR:    w_res = i_a ^ i_b;
      default:   w_res = i_b;
    endcase
  end

  always_comb begin
    o_result              = w_res;
    o_flags               = '0;
    o_flags[FLAG_ZERO]    = (w_res == '0);
    o_flags[FLAG_CARRY]   = w_carry;
  end

endmodule

// File: rtl/alu_regfile_pipe.sv
// alu_regfile_pipe: register file plus two-stage (EX -> WB) ALU pipeline
// with valid/ready handshakes on both sides.
//   clk, rst                 : clock, asynchronous active-high reset
//   in_valid / in_ready      : instruction handshake
//   op, rs1, rs2, rd         : operation and register indices
//   use_imm, imm             : select immediate as operand B
//   wr_en                    : write result back to reg[rd]
//   out_valid / out_ready    : result handshake
//   out_result, out_zero, out_carry : result and flags held in WB
//   dbg_addr / dbg_data      : combinational register read-back
module alu_regfile_pipe
  import alu_regfile_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NREGS = 8,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [AW-1:0]    rs1,
  input  logic [AW-1:0]    rs2,
  input  logic [AW-1:0]    rd,
  input  logic             use_imm,
  input  logic [WIDTH-1:0] imm,
  input  logic             wr_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_carry,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  logic [WIDTH-1:0]  r_regs [NREGS];

  logic              r_vld_p0;
  logic [WIDTH-1:0]  r_a_p0;
  logic [WIDTH-1:0]  r_b_p0;
  logic [2:0]        r_op_p0;
  logic [AW-1:0]     r_rd_p0;
  logic              r_wr_p0;

  logic              r_vld_p1;
  logic [WIDTH-1:0]  r_res_p1;
  logic              r_zero_p1;
  logic              r_carry_p1;

  logic              w_adv_p0;
  logic              w_accept;
  logic              w_wb_write;
  logic [WIDTH-1:0]  w_alu_res;
  logic [NFLAGS-1:0] w_alu_flags;
  logic [WIDTH-1:0]  w_rs1_val;
  logic [WIDTH-1:0]  w_rs2_val;
  logic [WIDTH-1:0]  w_a;
  logic [WIDTH-1:0]  w_b;

  alu_core #(.WIDTH(WIDTH)) u_alu (
    .i_a      (r_a_p0),
    .i_b      (r_b_p0),
    .i_op     (r_op_p0),
    .o_result (w_alu_res),
    .o_flags  (w_alu_flags)
  );

  assign w_adv_p0   = r_vld_p0 && (!r_vld_p1 || out_ready);
  assign in_ready   = !rst && (!r_vld_p0 || w_adv_p0);
  assign w_accept   = in_valid && in_ready;
  assign w_wb_write = w_adv_p0 && r_wr_p0 && (r_rd_p0 != '0);

  assign w_rs1_val  = (rs1 == '0) ? '0 : r_regs[rs1];
  assign w_rs2_val  = (rs2 == '0) ? '0 : r_regs[rs2];

  // The writing instruction leaves EX on the same edge this one is
  // captured, so its result is not in the register file yet: bypass it.
  assign w_a = (w_wb_write && (rs1 == r_rd_p0)) ? w_alu_res : w_rs1_val;
  assign w_b = use_imm ? imm :
               ((w_wb_write && (rs2 == r_rd_p0)) ? w_alu_res : w_rs2_val);

  assign dbg_data   = (dbg_addr == '0) ? '0 : r_regs[dbg_addr];

  assign out_valid  = r_vld_p1;
  assign out_result = r_res_p1;
  assign out_zero   = r_zero_p1;
  assign out_carry  = r_carry_p1;

  // Register file: written as the instruction moves from EX to WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_wb_write) begin
      r_regs[r_rd_p0] <= w_alu_res;
    end
  end

  // ---- stage p0 (EX): operand capture ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_vld_p0 <= 1'b0;
    else if (w_accept) r_vld_p0 <= 1'b1;
    else if (w_adv_p0) r_vld_p0 <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a_p0  <= w_a;
      r_b_p0  <= w_b;
      r_op_p0 <= op;
      r_rd_p0 <= rd;
      r_wr_p0 <= wr_en;
    end
  end

  // ---- stage p1 (WB): result and flags, held while the consumer stalls ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1   <= 1'b0;
      r_res_p1   <= '0;
      r_zero_p1  <= 1'b0;
      r_carry_p1 <= 1'b0;
    end else if (w_adv_p0) begin
      r_vld_p1   <= 1'b1;
      r_res_p1   <= w_alu_res;
      r_zero_p1  <= w_alu_flags[FLAG_ZERO];
      r_carry_p1 <= w_alu_flags[FLAG_CARRY];
    end else if (out_ready) begin
      r_vld_p1   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_regfile_pipe.sv
module tb_alu_regfile_pipe;

  localparam int WIDTH = 8;
  localparam int NREGS = 8;
  localparam int AW    = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       op = 3'b000;
  logic [AW-1:0]    rs1 = '0, rs2 = '0, rd = '0;
  logic             use_imm = 1'b0;
  logic [WIDTH-1:0] imm = '0;
  logic             wr_en = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_result;
  logic             out_zero, out_carry;
  logic [AW-1:0]    dbg_addr = '0;
  logic [WIDTH-1:0] dbg_data;

  alu_regfile_pipe #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rs1(rs1), .rs2(rs2), .rd(rd), .use_imm(use_imm), .imm(imm),
    .wr_en(wr_en), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_carry(out_carry),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] res;
    logic       z;
    logic       c;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic saw_in_stall = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Issue one instruction; the expected response is queued on the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [2:0] d, input logic [2:0] s1,
                       input logic [2:0] s2, input logic ui, input logic [7:0] im,
                       input logic we, input logic [7:0] er, input logic ez, input logic ec);
    int n = 0;
    op = o; rd = d; rs1 = s1; rs2 = s2; use_imm = ui; imm = im; wr_en = we;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        chk("accept_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    q.push_back('{res: er, z: ez, c: ec});
    #1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q.size() != 0 || out_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  task automatic chk_reg(input logic [2:0] a, input logic [7:0] e);
    dbg_addr = a;
    #1;
    chk($sformatf("dbg_r%0d", a), 32'(dbg_data), 32'(e));
  endtask

  always @(negedge clk) if (!rst && in_valid && !in_ready) saw_in_stall = 1'b1;

  // Monitor: pops the scoreboard on every handshake, checks hold-stability on stalls.
  logic       prev_stall = 1'b0;
  logic [9:0] held;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("wb_hold", {22'd0, out_valid, out_result, out_zero}, {22'd0, 1'b1, held[9:2], held[1]});
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 32'(out_result), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("result{res,z,c}", {22'd0, out_result, out_zero, out_carry},
              {22'd0, e.res, e.z, e.c});
        end
      end
      prev_stall = out_valid && !out_ready;
      held = {out_result, out_zero, out_carry};
    end
  end

  initial begin
    // Reset state
    #2;
    for (int i = 0; i < NREGS; i++) chk_reg(3'(i), 8'h00);
    chk("in_ready_in_rst", 32'(in_ready), 32'd0);
    chk("out_valid_in_rst", 32'(out_valid), 32'd0);
    @(posedge clk); #3; rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Back-to-back with forwarding
    issue(3'b100, 3'd1, 3'd0, 3'd0, 1'b1, 8'hF0, 1'b1, 8'hF0, 1'b0, 1'b0);
    issue(3'b100, 3'd2, 3'd1, 3'd0, 1'b1, 8'h20, 1'b1, 8'h10, 1'b0, 1'b1);
    issue(3'b101, 3'd3, 3'd1, 3'd1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1);
    issue(3'b111, 3'd6, 3'd0, 3'd0, 1'b1, 8'hFF, 1'b1, 8'hFF, 1'b0, 1'b0);
    issue(3'b010, 3'd4, 3'd6, 3'd6, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
    // r0 write is ignored and must not be forwarded either
    issue(3'b111, 3'd0, 3'd0, 3'd0, 1'b1, 8'h55, 1'b1, 8'h55, 1'b0, 1'b0);
    issue(3'b111, 3'd5, 3'd0, 3'd0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
    in_valid = 1'b0;
    wait_drain();
    chk_reg(3'd0, 8'h00); chk_reg(3'd1, 8'hF0); chk_reg(3'd2, 8'h10);
    chk_reg(3'd3, 8'h00); chk_reg(3'd6, 8'hFF); chk_reg(3'd5, 8'h00);

    // Stream of 6 with a 3-cycle consumer stall in the middle
    @(posedge clk); #1;
    saw_in_stall = 1'b0;
    fork
      begin
        issue(3'b001, 3'd7, 3'd1, 3'd0, 1'b1, 8'h0F, 1'b1, 8'hFF, 1'b0, 1'b0);
        issue(3'b000, 3'd7, 3'd7, 3'd0, 1'b1, 8'h3C, 1'b1, 8'h3C, 1'b0, 1'b0);
        issue(3'b110, 3'd7, 3'd7, 3'd0, 1'b1, 8'hFF, 1'b1, 8'hC3, 1'b0, 1'b0);
        issue(3'b100, 3'd7, 3'd7, 3'd0, 1'b1, 8'h3D, 1'b1, 8'h00, 1'b1, 1'b1);
        issue(3'b011, 3'd5, 3'd7, 3'd0, 1'b1, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b0);
        issue(3'b101, 3'd5, 3'd5, 3'd0, 1'b1, 8'h01, 1'b1, 8'hFE, 1'b0, 1'b1);
        in_valid = 1'b0;
      end
      begin
        repeat (2) @(posedge clk);
        #2 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2 out_ready = 1'b1;
      end
    join
    wait_drain();
    chk("in_ready_dropped", 32'(saw_in_stall), 32'd1);
    chk_reg(3'd7, 8'h00); chk_reg(3'd5, 8'hFE);

    // Reset with EX and WB both occupied
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(3'b100, 3'd2, 3'd0, 3'd0, 1'b1, 8'h77, 1'b1, 8'h77, 1'b0, 1'b0);
    issue(3'b100, 3'd3, 3'd0, 3'd0, 1'b1, 8'h11, 1'b1, 8'h11, 1'b0, 1'b0);
    in_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("out_valid_on_rst", 32'(out_valid), 32'd0);
    chk("in_ready_on_rst", 32'(in_ready), 32'd0);
    q.delete();
    chk_reg(3'd2, 8'h00); chk_reg(3'd3, 8'h00); chk_reg(3'd1, 8'h00);
    out_ready = 1'b1;
    @(posedge clk); #3; rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst2", 32'(in_ready), 32'd1);
    chk("out_valid_after_rst2", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    // Latency: accept at edge N, out_valid only after edge N+1
    issue(3'b100, 3'd1, 3'd2, 3'd0, 1'b1, 8'h01, 1'b1, 8'h01, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("latency_not_yet", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("latency_valid", 32'(out_valid), 32'd1);
    wait_drain();
    chk_reg(3'd1, 8'h01);

    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
